debounce_bank: RTL and testbench

//  N-channel debouncer for the vending-machine front panel (coin slots, item and cancel keys).
//  Per channel: 2-FF synchroniser, stability counter, clean level, one-cycle rise/fall pulses,

---
 rtl/debounce_bank_if.sv | 23 ++
 rtl/debounce_bank.sv | 114 +++++++++++
 tb/tb_debounce_bank.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/debounce_bank_if.sv
// Front-panel debouncer bundle: raw pins in, clean levels and event pulses out.
// slave side is the debouncer, master side is the consumer/driver of pins.
interface debounce_bank_if #(
  parameter int N = 4
);
  logic [N-1:0] in;
  logic [N-1:0] steady;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic [N-1:0] long;
  logic [N-1:0] rpt;
  logic         any_evt;

  modport master (
    output in,
    input  steady, rise, fall, long, rpt, any_evt
  );

  modport slave (
    input  in,
    output steady, rise, fall, long, rpt, any_evt
  );
endinterface

// File: rtl/debounce_bank.sv
// N-channel key/coin debouncer: synchroniser, stability count, edge pulses,
// long-press and auto-repeat; every channel is independent.
module debounce_bank #(
  parameter int           N             = 4,
  parameter int           CNT_W         = 25,
  parameter int           LIMIT         = 1500000,
  parameter int           HOLD_W        = 32,
  parameter int           HOLD_CYCLES   = 50000000,
  parameter int           REPEAT_CYCLES = 10000000,
  parameter logic [N-1:0] INVERT        = '0,
  parameter logic [N-1:0] RESET_VAL     = '0
) (
  input logic           clk,
  input logic           reset,
  debounce_bank_if.slave bus
);

  localparam logic [CNT_W-1:0]  LIM =
    CNT_W'(LIMIT);
  localparam logic [HOLD_W-1:0] HLD =
    HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] TOP =
    HOLD_W'(HOLD_CYCLES + REPEAT_CYCLES);
  localparam logic [HOLD_W-1:0] RLD =
    HOLD_W'(HOLD_CYCLES + 1);
  localparam bit RPT_EN = REPEAT_CYCLES > 0;

  logic [N-1:0] sync1, sync2, old, steady;
  logic [N-1:0] rise, fall, long, rpt;
  logic         any_evt;
  logic [CNT_W-1:0]  cnt  [N];
  logic [HOLD_W-1:0] hcnt [N];

  logic [N-1:0] old_n, steady_n;
  logic [N-1:0] rise_n, fall_n, long_n, rpt_n;
  logic [CNT_W-1:0]  cnt_n  [N];
  logic [HOLD_W-1:0] hcnt_n [N];

  always_comb begin
    old_n    = old;
    steady_n = steady;
    rise_n   = '0;
    fall_n   = '0;
    long_n   = '0;
    rpt_n    = '0;
    for (int i = 0; i < N; i++) begin
      cnt_n[i]  = cnt[i];
      hcnt_n[i] = hcnt[i];
      if (sync2[i] != old[i]) begin
        old_n[i] = sync2[i];
        cnt_n[i] = '0;
      end else if (cnt[i] == LIM) begin
        if (steady[i] != old[i]) begin
          steady_n[i] = old[i];
          rise_n[i]   = old[i];
          fall_n[i]   = ~old[i];
        end
      end else begin
        cnt_n[i] = cnt[i] + 1'b1;
      end
      // repeat period comes from reloading just past the long-press mark
      if (!steady_n[i] || rise_n[i])
        hcnt_n[i] = '0;
      else if (hcnt[i] == TOP)
        hcnt_n[i] = RPT_EN ? RLD : TOP;
      else
        hcnt_n[i] = hcnt[i] + 1'b1;
      long_n[i] = (hcnt_n[i] == HLD) &&
                  (hcnt[i] != HLD);
      rpt_n[i]  = RPT_EN &&
                  (hcnt_n[i] == TOP);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= RESET_VAL;
      sync2   <= RESET_VAL;
      old     <= RESET_VAL;
      steady  <= RESET_VAL;
      rise    <= '0;
      fall    <= '0;
      long    <= '0;
      rpt     <= '0;
      any_evt <= 1'b0;
      for (int i = 0; i < N; i++) begin
        cnt[i]  <= '0;
        hcnt[i] <= '0;
      end
    end else begin
      sync1   <= bus.in ^ INVERT;
      sync2   <= sync1;
      old     <= old_n;
      steady  <= steady_n;
      rise    <= rise_n;
      fall    <= fall_n;
      long    <= long_n;
      rpt     <= rpt_n;
      any_evt <= |(rise_n | long_n | rpt_n);
      for (int i = 0; i < N; i++) begin
        cnt[i]  <= cnt_n[i];
        hcnt[i] <= hcnt_n[i];
      end
    end
  end

  assign bus.steady  = steady;
  assign bus.rise    = rise;
  assign bus.fall    = fall;
  assign bus.long    = long;
  assign bus.rpt     = rpt;
  assign bus.any_evt = any_evt;

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: directed panel scenarios plus random pin
// activity, scored against a sliding-window / press-age reference model.
module tb_debounce_bank;

  localparam int N   = 4;
  localparam int LIM = 4;
  localparam int H   = 20;
  localparam int R   = 5;
  localparam logic [N-1:0] INV = 4'b1000;
  localparam logic [N-1:0] RV  = 4'b0000;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  debounce_bank_if #(.N(N)) bus ();

  debounce_bank #(
    .N(N), .CNT_W(3), .LIMIT(LIM),
    .HOLD_W(8), .HOLD_CYCLES(H),
    .REPEAT_CYCLES(R),
    .INVERT(INV), .RESET_VAL(RV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // model: effective-pin history, steady follows a full agreeing window
  logic [N-1:0] h [$];
  logic [N-1:0] m_steady, m_rise, m_fall;
  logic [N-1:0] m_long, m_rpt;
  logic         m_any;
  int           age [N];
  bit           armed = 0;
  int           last;
  bit           same;

  always @(posedge clk) begin
    if (reset) begin
      h.delete();
      repeat (LIM + 4) h.push_back(RV);
      m_steady = RV;
      m_rise   = '0;
      m_fall   = '0;
      m_long   = '0;
      m_rpt    = '0;
      m_any    = 1'b0;
      for (int i = 0; i < N; i++) age[i] = -1;
      armed = 1;
    end else begin
      m_rise = '0;
      m_fall = '0;
      m_long = '0;
      m_rpt  = '0;
      last   = h.size() - 2;
      for (int i = 0; i < N; i++) begin
        same = 1;
        for (int k = 1; k <= LIM + 1; k++)
          if (h[last-k][i] != h[last][i]) same = 0;
        if (same && h[last][i] != m_steady[i]) begin
          m_steady[i] = h[last][i];
          m_rise[i]   = h[last][i];
          m_fall[i]   = !h[last][i];
        end
        if (!m_steady[i])   age[i] = -1;
        else if (m_rise[i]) age[i] = 0;
        else                age[i] = age[i] + 1;
        m_long[i] = (age[i] == H);
        m_rpt[i]  = (R > 0) && (age[i] > H) &&
                    ((age[i] - H) % R == 0);
      end
      m_any = |(m_rise | m_long | m_rpt);
      h.push_back(bus.in ^ INV);
      void'(h.pop_front());
    end
  end

  int nrise [N];
  int nlong [N];
  int nrpt  [N];

  always @(negedge clk) begin
    if (armed) begin
      chk("steady", bus.steady, m_steady);
      chk("rise",   bus.rise,   m_rise);
      chk("fall",   bus.fall,   m_fall);
      chk("long",   bus.long,   m_long);
      chk("repeat", bus.rpt,    m_rpt);
      chk("any_evt", bus.any_evt, m_any);
      for (int i = 0; i < N; i++) begin
        nrise[i] += int'(bus.rise[i]);
        nlong[i] += int'(bus.long[i]);
        nrpt[i]  += int'(bus.rpt[i]);
      end
    end
  end

  task automatic drive(input logic [N-1:0] e);
    bus.in = e ^ INV;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int snap_r, snap_l, snap_p;
  logic [N-1:0] cur;

  initial begin
    for (int i = 0; i < N; i++) begin
      nrise[i] = 0;
      nlong[i] = 0;
      nrpt[i]  = 0;
    end
    bus.in = 4'hF;
    reset  = 1'b1;
    cyc(2);
    chk("rst_steady", bus.steady, 0);
    chk("rst_pulses",
        {bus.rise, bus.fall, bus.long, bus.rpt}, 0);
    chk("rst_any", bus.any_evt, 0);

    reset = 1'b0;
    drive(4'hF);
    for (int n = 0; n <= LIM + 3; n++) begin
      @(posedge clk);
      #1;
      chk("lat_steady", bus.steady,
          n == LIM + 3 ? 4'hF : 4'h0);
      chk("lat_rise", bus.rise,
          n == LIM + 3 ? 4'hF : 4'h0);
    end
    @(negedge clk);
    drive(4'h0);
    cyc(12);

    snap_r = nrise[0];
    drive(4'h1);
    cyc(5);
    drive(4'h0);
    cyc(14);
    chk("glitch5_rise", nrise[0] - snap_r, 0);
    drive(4'h1);
    cyc(7);
    drive(4'h0);
    cyc(14);
    chk("glitch7_rise", nrise[0] - snap_r, 1);

    snap_r = nrise[1];
    for (int k = 0; k < 10; k++) begin
      drive(k % 2 == 0 ? 4'h2 : 4'h0);
      cyc(2);
    end
    drive(4'h2);
    cyc(14);
    chk("bounce_rise", nrise[1] - snap_r, 1);
    drive(4'h0);
    cyc(12);

    snap_l = nlong[2];
    snap_p = nrpt[2];
    drive(4'h4);
    cyc(LIM + 3 + 40);
    chk("hold_long", nlong[2] - snap_l, 1);
    chk("hold_rpt", nrpt[2] - snap_p, 3);
    drive(4'h0);
    cyc(10);
    snap_p = nrpt[2];
    snap_l = nlong[2];
    cyc(10);
    chk("post_rel", (nrpt[2] - snap_p) +
                    (nlong[2] - snap_l), 0);

    snap_r = nrise[2];
    snap_p = nrpt[2];
    drive(4'h4);
    cyc(LIM + 3 + 22);
    reset = 1'b1;
    cyc(1);
    chk("midrst_out",
        {bus.steady, bus.rise, bus.fall,
         bus.long, bus.rpt}, 0);
    chk("midrst_any", bus.any_evt, 0);
    reset = 1'b0;
    cyc(14);
    chk("midrst_rpt", nrpt[2] - snap_p, 0);
    chk("midrst_rise", nrise[2] - snap_r, 2);
    drive(4'h0);
    cyc(12);

    drive(4'h9);
    for (int n = 0; n <= LIM + 3; n++) begin
      @(posedge clk);
      #1;
      chk("simul_rise", bus.rise,
          n == LIM + 3 ? 4'h9 : 4'h0);
    end
    @(negedge clk);
    cyc(5);
    drive(4'h0);
    cyc(12);

    repeat (150) begin
      cur = N'($urandom);
      drive(cur);
      reset = ($urandom_range(0, 24) == 0);
      cyc(1);
      reset = 1'b0;
      cyc($urandom_range(0, 3) == 0 ?
          $urandom_range(20, 45) :
          $urandom_range(1, 9));
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
